// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for pipeline stage buffers.
//   NOP_INS        : bubble instruction presented downstream when a stage is empty
//   pipe_entry_t   : {ins, pc} pair at the default widths
//   MAX_PIPE_DEPTH : largest supported skid storage depth
//   CNT_BITS       : occupancy counter width able to hold 0..MAX_PIPE_DEPTH
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_INS_W      = 32;
    localparam int DEF_PC_W       = 32;
    localparam int MAX_PIPE_DEPTH = 4;
    localparam int CNT_BITS       = $clog2(MAX_PIPE_DEPTH + 1);

    localparam logic [DEF_INS_W-1:0] NOP_INS = 32'h0;

    typedef struct packed {
        logic [DEF_INS_W-1:0] ins;
        logic [DEF_PC_W-1:0]  pc;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_skid_mem.sv
// ---------------------------------------------------------------------------
// pipe_skid_mem
// DEPTH-entry storage for a pipeline stage: one write port, one read port.
// Read is combinational so a freshly written entry is visible the cycle after
// the write edge. Entries are not reset; the owner only reads valid slots.
// Ports:
//   clk     in   rising-edge clock
//   wr_en   in   write entry at wr_ptr
//   wr_ptr  in   write slot
//   wr_ins  in   instruction to store
//   wr_pc   in   PC to store
//   rd_ptr  in   read slot
//   rd_ins  out  instruction at rd_ptr
//   rd_pc   out  PC at rd_ptr
// ---------------------------------------------------------------------------
module pipe_skid_mem #(
    parameter int INS_W = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [INS_W-1:0] wr_ins,
    input  logic [PC_W-1:0]  wr_pc,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [INS_W-1:0] rd_ins,
    output logic [PC_W-1:0]  rd_pc
);

    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ptr == PTR_W'(i)) begin
                    ins_mem[i] <= wr_ins;
                    pc_mem[i]  <= wr_pc;
                end
            end
        end
    end

    // Explicit slot compare keeps out-of-range pointer codes (non power-of-2
    // depths) from indexing past the array.
    always_comb begin
        rd_ins = '0;
        rd_pc  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PTR_W'(i)) begin
                rd_ins = ins_mem[i];
                rd_pc  = pc_mem[i];
            end
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
// Pipeline stage register with valid/ready handshake, flush-to-bubble and
// DEPTH-entry skid storage (DEPTH=1 plain register, DEPTH>=2 skid buffer
// with registered in_ready). Each entry carries an instruction and its PC.
// Optional feature macro: PIPE_STATS_EN enables saturating stall/flush
// counters; without it stall_cnt/flush_cnt read 0.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   upstream offers in_ins/in_pc
//   in_ready   out  stage accepts an entry this cycle
//   in_ins     in   incoming instruction
//   in_pc      in   incoming PC
//   flush      in   drop all held entries and the incoming one
//   out_valid  out  head entry valid
//   out_ready  in   downstream consumes head (0 = stall)
//   out_ins    out  head instruction, NOP when empty
//   out_pc     out  head PC, 0 when empty
//   stall_cnt  out  cycles with out_valid & ~out_ready
//   flush_cnt  out  flushes that discarded at least one valid entry
// ---------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int INS_W = DEF_INS_W,
    parameter int PC_W  = DEF_PC_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                  PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C  = CNT_BITS'(DEPTH);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);

    logic [CNT_BITS-1:0] count_reg, count_next;
    logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
    logic                live_reg;
    logic                push, pop, full, empty;
    logic [INS_W-1:0]    rd_ins;
    logic [PC_W-1:0]     rd_pc;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_C);
    assign out_valid = ~empty;

    // live_reg holds in_ready low during reset and for the release cycle.
    generate
        if (DEPTH == 1) begin : g_ready_pass
            // Full register may still accept when the head leaves this cycle.
            assign in_ready = live_reg & (~full | out_ready);
        end else begin : g_ready_reg
            // Registers only: no combinational out_ready -> in_ready path.
            assign in_ready = live_reg & ~full;
        end
    endgenerate

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            live_reg   <= 1'b0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            live_reg   <= 1'b1;
        end
    end

    pipe_skid_mem #(
        .INS_W (INS_W),
        .PC_W  (PC_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push & ~flush),
        .wr_ptr (wr_ptr_reg),
        .wr_ins (in_ins),
        .wr_pc  (in_pc),
        .rd_ptr (rd_ptr_reg),
        .rd_ins (rd_ins),
        .rd_pc  (rd_pc)
    );

    // Empty stage presents a bubble so downstream never sees stale data.
    assign out_ins = out_valid ? rd_ins : INS_W'(NOP_INS);
    assign out_pc  = out_valid ? rd_pc  : '0;

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Saturating; only reset clears them so history survives flushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt_reg))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush && !empty && !(&flush_cnt_reg))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
// Directed vectors against two instances: u_a (DEPTH=2, CNT_W=16) and
// u_b (DEPTH=1, CNT_W=2). Counter expectations follow PIPE_STATS_EN.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;
    import pipe_pkg::*;

`ifdef PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [31:0] a_in_ins, a_in_pc, a_out_ins, a_out_pc;
    logic [15:0] a_stall_cnt, a_flush_cnt;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [31:0] b_in_ins, b_in_pc, b_out_ins, b_out_pc;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    pipe_stage_buf #(.INS_W(32), .PC_W(32), .DEPTH(2), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ins(a_in_ins), .in_pc(a_in_pc),
        .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ins(a_out_ins), .out_pc(a_out_pc),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_buf #(.INS_W(32), .PC_W(32), .DEPTH(1), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ins(b_in_ins), .in_pc(b_in_pc),
        .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ins(b_out_ins), .out_pc(b_out_pc),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %-14s %h", tag, got);
        end
    endtask

    function automatic logic [63:0] stat(input logic [63:0] v);
        return STATS ? v : 64'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    pipe_entry_t stream [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        a_in_valid = 0; a_flush = 0; a_out_ready = 0; a_in_ins = '0; a_in_pc = '0;
        b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_in_ins = '0; b_in_pc = '0;
        for (int i = 0; i < 4; i++) begin
            stream[i].ins = 32'h100 + 32'(i);
            stream[i].pc  = 32'h14 + 32'(4 * i);
        end

        // Reset held low
        repeat (2) step();
        check_vec("rst_a_ready",  64'(a_in_ready),  64'h0);
        check_vec("rst_b_ready",  64'(b_in_ready),  64'h0);
        check_vec("rst_a_valid",  64'(a_out_valid), 64'h0);
        check_vec("rst_a_ins",    64'(a_out_ins),   64'h0);
        #2 reset = 1'b1;
        #1 check_vec("rel_a_ready0", 64'(a_in_ready), 64'h0);
        step();
        check_vec("rel_a_ready1", 64'(a_in_ready), 64'h1);
        check_vec("rel_b_ready1", 64'(b_in_ready), 64'h1);

        // Single push, one-cycle latency, then 1/cycle stream
        a_in_valid = 1; a_in_ins = 32'h8C220004; a_in_pc = 32'h10; a_out_ready = 1;
        step();
        check_vec("lat_valid", 64'(a_out_valid), 64'h1);
        check_vec("lat_ins",   64'(a_out_ins),   64'h8C220004);
        check_vec("lat_pc",    64'(a_out_pc),    64'h10);
        for (int i = 0; i < 4; i++) begin
            a_in_ins = stream[i].ins; a_in_pc = stream[i].pc;
            step();
            check_vec("strm_ins",   64'(a_out_ins),  64'(stream[i].ins));
            check_vec("strm_pc",    64'(a_out_pc),   64'(stream[i].pc));
            check_vec("strm_ready", 64'(a_in_ready), 64'h1);
        end
        a_in_valid = 0;
        step();
        check_vec("drain_valid", 64'(a_out_valid), 64'h0);
        check_vec("drain_ins",   64'(a_out_ins),   64'h0);
        check_vec("drain_pc",    64'(a_out_pc),    64'h0);

        // Back-pressure: fill, hold with blocked push, then drain in order
        a_out_ready = 0; a_in_valid = 1; a_in_ins = 32'hA; a_in_pc = 32'h40;
        step();
        check_vec("bp_ready1", 64'(a_in_ready), 64'h1);
        check_vec("bp_head_a", 64'(a_out_ins),  64'hA);
        a_in_ins = 32'hB; a_in_pc = 32'h44;
        step();
        check_vec("bp_full_rdy", 64'(a_in_ready), 64'h0);
        a_in_ins = 32'hC; a_in_pc = 32'h48;
        repeat (4) step();
        check_vec("bp_hold_ins", 64'(a_out_ins),   64'hA);
        check_vec("bp_hold_rdy", 64'(a_in_ready),  64'h0);
        check_vec("bp_stall5",   64'(a_stall_cnt), stat(64'd5));
        a_out_ready = 1; a_in_ins = 32'hD; a_in_pc = 32'h4C;
        step();
        check_vec("pop_only_ins", 64'(a_out_ins),  64'hB);
        check_vec("pop_only_pc",  64'(a_out_pc),   64'h44);
        check_vec("pop_only_rdy", 64'(a_in_ready), 64'h1);
        a_in_valid = 0;
        step();
        check_vec("bp_no_dup", 64'(a_out_valid), 64'h0);

        // Flush with two held entries and an incoming one
        a_out_ready = 0; a_in_valid = 1; a_in_ins = 32'hE; a_in_pc = 32'h50;
        step();
        a_in_ins = 32'hF; a_in_pc = 32'h54;
        step();
        a_flush = 1; a_in_ins = 32'h6; a_in_pc = 32'h58;
        step();
        a_flush = 0; a_in_valid = 0;
        check_vec("fl_valid",  64'(a_out_valid), 64'h0);
        check_vec("fl_ins",    64'(a_out_ins),   64'h0);
        check_vec("fl_pc",     64'(a_out_pc),    64'h0);
        check_vec("fl_cnt1",   64'(a_flush_cnt), stat(64'd1));
        check_vec("fl_stall7", 64'(a_stall_cnt), stat(64'd7));
        check_vec("fl_ready",  64'(a_in_ready),  64'h1);
        step();
        check_vec("fl_drop_in", 64'(a_out_valid), 64'h0);
        a_flush = 1;
        step();
        a_flush = 0;
        check_vec("fl_empty_cnt", 64'(a_flush_cnt), stat(64'd1));
        a_in_valid = 1; a_in_ins = 32'h7; a_in_pc = 32'h60; a_out_ready = 1;
        step();
        a_in_valid = 0;
        check_vec("post_fl_ins", 64'(a_out_ins), 64'h7);
        check_vec("post_fl_pc",  64'(a_out_pc),  64'h60);
        step();

        // DEPTH=1: full + out_ready replaces the entry; 2-bit counter saturates
        b_out_ready = 0; b_in_valid = 1; b_in_ins = 32'h3; b_in_pc = 32'h30;
        step();
        b_in_valid = 0;
        check_vec("d1_ins3",    64'(b_out_ins),  64'h3);
        check_vec("d1_full_rdy", 64'(b_in_ready), 64'h0);
        repeat (4) step();
        check_vec("d1_stall_sat", 64'(b_stall_cnt), stat(64'd3));
        b_out_ready = 1; b_in_valid = 1; b_in_ins = 32'h5; b_in_pc = 32'h50;
        #1 check_vec("d1_pass_rdy", 64'(b_in_ready), 64'h1);
        step();
        b_in_valid = 0;
        check_vec("d1_repl_val", 64'(b_out_valid), 64'h1);
        check_vec("d1_repl_ins", 64'(b_out_ins),   64'h5);
        check_vec("d1_repl_pc",  64'(b_out_pc),    64'h50);
        step();
        check_vec("d1_empty", 64'(b_out_valid), 64'h0);

        // Asynchronous reset with two entries held
        a_out_ready = 0; a_in_valid = 1; a_in_ins = 32'h11; a_in_pc = 32'h70;
        step();
        a_in_ins = 32'h12; a_in_pc = 32'h74;
        step();
        a_in_valid = 0;
        check_vec("pre_rst_val", 64'(a_out_valid), 64'h1);
        #2 reset = 1'b0;
        #1;
        check_vec("arst_valid", 64'(a_out_valid), 64'h0);
        check_vec("arst_ins",   64'(a_out_ins),   64'h0);
        check_vec("arst_ready", 64'(a_in_ready),  64'h0);
        check_vec("arst_stall", 64'(a_stall_cnt), 64'h0);
        step();
        #2 reset = 1'b1;
        #1 check_vec("arel_ready0", 64'(a_in_ready), 64'h0);
        step();
        check_vec("arel_ready1", 64'(a_in_ready),  64'h1);
        check_vec("arel_valid",  64'(a_out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
